// File: rtl/fp_rx_fib_check_pkg.sv
// Shared definitions for the four-phase dual-rail (FP) Fibonacci link receiver.
// Holds rail index constants, the receiver state type and the
// per-pair dual-rail decode helper.
package fp_pkg;

    localparam int unsigned RAIL_T = 1;  // true rail index within a pair
    localparam int unsigned RAIL_F = 0;  // false rail index within a pair

    localparam string FP_ENCODING = "FP";

    typedef enum logic {
        WAIT_DATA,
        WAIT_NULL
    } rx_state_t;

    typedef struct packed {
        logic valid;    // 01 or 10
        logic is_null;  // 00
        logic illegal;  // 11
        logic value;    // decoded bit, meaningful only when valid
    } fp_dec_t;

    function automatic fp_dec_t fp_decode(input logic [1:0] code);
        fp_dec_t d;
        d.valid   = code[RAIL_T] ^ code[RAIL_F];
        d.is_null = ~(code[RAIL_T] | code[RAIL_F]);
        d.illegal = code[RAIL_T] & code[RAIL_F];
        d.value   = code[RAIL_T];
        return d;
    endfunction

endpackage

// File: rtl/fp_rx_fib_check_sync.sv
// Multi-flop synchroniser applied to a vector of independent rails.
// Ports:
//   i_clk   - destination clock
//   i_rst_n - synchronous active-low reset, clears every stage
//   i_d     - asynchronous rail inputs
//   o_q     - synchronised rails (last stage)
module fp_rail_sync #(
    parameter int unsigned W      = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [STAGES-1:0][W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else begin
            r_q[0] <= i_d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_q[i] <= r_q[i-1];
            end
        end
    end

    assign o_q = r_q[STAGES-1];

endmodule

// File: rtl/fp_rx_fib_check.sv
// Clocked receiver/checker for the FP dual-rail output of the async
// Fibonacci generator. Synchronises all rails, completes the four-phase
// handshake, strobes each received word and checks it against the
// recurrence w[n] = w[n-1] + w[n-2] mod 2^WIDTH.
// Ports:
//   clk         - system clock
//   rst         - synchronous active-low reset
//   in          - dual-rail data, [i][1]=true rail, [i][0]=false rail
//   ack_o       - four-phase acknowledge (registered)
//   data_o      - last captured word
//   valid_o     - one-cycle strobe when data_o updates
//   err_o       - sticky recurrence mismatch
//   proto_err_o - sticky illegal rail code seen
//   word_cnt_o  - saturating count of received words
module fp_rx_fib_check
    import fp_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0][1:0] in,
    output logic                  ack_o,
    output logic [WIDTH-1:0]      data_o,
    output logic                  valid_o,
    output logic                  err_o,
    output logic                  proto_err_o,
    output logic [CNT_WIDTH-1:0]  word_cnt_o
);

    logic [WIDTH-1:0][1:0] w_sync;
    logic                  w_all_valid;
    logic                  w_all_null;
    logic                  w_any_ill;
    logic [WIDTH-1:0]      w_word;
    logic [WIDTH-1:0]      w_expect;
    logic                  w_capture;
    rx_state_t             w_state_nxt;

    rx_state_t             r_state;
    logic                  r_ack;
    logic                  r_valid;
    logic [WIDTH-1:0]      r_data;
    logic [WIDTH-1:0]      r_p1;
    logic [WIDTH-1:0]      r_p2;
    logic [1:0]            r_seed;
    logic                  r_chk_fail;
    logic                  r_err;
    logic                  r_proto;
    logic [CNT_WIDTH-1:0]  r_cnt;

    fp_rail_sync #(
        .W      (2 * WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_d     (in),
        .o_q     (w_sync)
    );

    always_comb begin
        fp_dec_t v_dec;
        w_all_valid = 1'b1;
        w_all_null  = 1'b1;
        w_any_ill   = 1'b0;
        w_word      = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            v_dec       = fp_decode(w_sync[i]);
            w_all_valid = w_all_valid & v_dec.valid;
            w_all_null  = w_all_null & v_dec.is_null;
            w_any_ill   = w_any_ill | v_dec.illegal;
            w_word[i]   = v_dec.value;
        end
    end

    // carry out of the top bit is intentionally dropped
    assign w_expect = r_p1 + r_p2;

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            WAIT_DATA: begin
                if (w_all_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = WAIT_NULL;
                end
            end
            WAIT_NULL: begin
                if (w_all_null) begin
                    w_state_nxt = WAIT_DATA;
                end
            end
            default: w_state_nxt = WAIT_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= WAIT_DATA;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Mismatch is judged at capture and folded into err_o one edge after
    // the valid strobe; r_seed saturates at 2 so word_cnt saturation
    // never disturbs checking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ack      <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_p1       <= '0;
            r_p2       <= '0;
            r_seed     <= '0;
            r_chk_fail <= 1'b0;
            r_err      <= 1'b0;
            r_proto    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_ack      <= (w_state_nxt == WAIT_NULL);
            r_valid    <= w_capture;
            r_chk_fail <= w_capture && (r_seed == 2'd2) && (w_word != w_expect);
            r_err      <= r_err | r_chk_fail;
            r_proto    <= r_proto | w_any_ill;
            if (w_capture) begin
                r_data <= w_word;
                r_p1   <= w_word;
                r_p2   <= r_p1;
                if (r_seed != 2'd2) begin
                    r_seed <= r_seed + 2'd1;
                end
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign ack_o       = r_ack;
    assign valid_o     = r_valid;
    assign data_o      = r_data;
    assign err_o       = r_err;
    assign proto_err_o = r_proto;
    assign word_cnt_o  = r_cnt;

endmodule

// File: tb/tb_fp_rx_fib_check.sv
// Self-checking bench for fp_rx_fib_check: directed handshake/protocol
// scenarios followed by randomized word streams, checked against a
// list-based model of the Fibonacci rule and the saturating word count.
module tb_fp_rx_fib_check;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;   // small counter so saturation is reachable
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [W-1:0][1:0]   r_in = '0;
    logic                ack_o;
    logic [W-1:0]        data_o;
    logic                valid_o;
    logic                err_o;
    logic                proto_err_o;
    logic [CW-1:0]       word_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int  m_words[$];
    bit  m_err;

    fp_rx_fib_check #(
        .WIDTH       (W),
        .SYNC_STAGES (2),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (r_in),
        .ack_o       (ack_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .err_o       (err_o),
        .proto_err_o (proto_err_o),
        .word_cnt_o  (word_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0][1:0] cw(input logic [W-1:0] w);
        logic [W-1:0][1:0] c;
        for (int i = 0; i < W; i++) c[i] = w[i] ? 2'b10 : 2'b01;
        return c;
    endfunction

    function automatic int model_cnt();
        return (m_words.size() > CNT_MAX) ? CNT_MAX : m_words.size();
    endfunction

    // Push a received word into the model and update the expected error flag.
    task automatic model_push(input int w);
        int n;
        m_words.push_back(w);
        n = m_words.size();
        if (n >= 3 && w != ((m_words[n-2] + m_words[n-3]) % 256)) m_err = 1'b1;
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        r_in = '0;
        step();
        step();
        chk("rst_ack", 32'(ack_o), 0);
        chk("rst_cnt", 32'(word_cnt_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_proto", 32'(proto_err_o), 0);
        rst = 1'b1;
        m_words.delete();
        m_err = 1'b0;
    endtask

    // Full four-phase transfer of one word, optionally with bits arriving staggered.
    task automatic send_word(input logic [W-1:0] w, input bit stagger);
        bit got;
        bit err_before;
        logic [W-1:0][1:0] full;
        full = cw(w);
        if (stagger) begin
            logic [W-1:0] mask;
            mask = W'($urandom);
            for (int i = 0; i < W; i++) r_in[i] = mask[i] ? full[i] : 2'b00;
            repeat ($urandom_range(0, 3)) step();
        end
        r_in = full;
        got = 1'b0;
        for (int k = 0; k < 16 && !got; k++) begin
            step();
            if (valid_o === 1'b1) got = 1'b1;
        end
        chk("valid_seen", 32'(got), 1);
        err_before = m_err;
        model_push(int'(w));
        chk("cap_ack", 32'(ack_o), 1);
        chk("cap_data", 32'(data_o), 32'(w));
        chk("cap_cnt", 32'(word_cnt_o), 32'(model_cnt()));
        chk("cap_err_prev", 32'(err_o), 32'(err_before));
        step();
        chk("valid_single", 32'(valid_o), 0);
        chk("err_after", 32'(err_o), 32'(m_err));
        r_in = '0;
        got = 1'b0;
        for (int k = 0; k < 16 && !got; k++) begin
            step();
            if (ack_o === 1'b0) got = 1'b1;
        end
        chk("ack_fall_seen", 32'(got), 1);
    endtask

    initial begin
        int fib_seq[15] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121};
        int bad_seq[6]  = '{0, 1, 1, 3, 4, 7};
        bit seen;
        logic [W-1:0] w;
        int n;

        m_err = 1'b0;

        // 1: reset held with a codeword present, then captured on release
        rst  = 1'b0;
        r_in = cw(8'h05);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_ack", 32'(ack_o), 0);
            chk("t1_valid", 32'(valid_o), 0);
            chk("t1_data", 32'(data_o), 0);
            chk("t1_cnt", 32'(word_cnt_o), 0);
            chk("t1_errs", 32'({err_o, proto_err_o}), 0);
        end
        rst = 1'b1;
        step();
        chk("t1_ack_e1", 32'(ack_o), 0);
        step();
        chk("t1_ack_e2", 32'(ack_o), 0);
        step();
        chk("t1_ack_e3", 32'(ack_o), 1);
        chk("t1_valid_e3", 32'(valid_o), 1);
        chk("t1_data_e3", 32'(data_o), 5);
        chk("t1_cnt_e3", 32'(word_cnt_o), 1);

        // 2: exact handshake latency and hold behaviour
        do_reset();
        r_in = cw(8'hA3);
        step();
        chk("t2_ack_e1", 32'(ack_o), 0);
        step();
        chk("t2_ack_e2", 32'(ack_o), 0);
        step();
        chk("t2_ack_e3", 32'(ack_o), 1);
        chk("t2_valid_e3", 32'(valid_o), 1);
        chk("t2_data", 32'(data_o), 32'hA3);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t2_hold_ack", 32'(ack_o), 1);
            chk("t2_hold_valid", 32'(valid_o), 0);
        end
        r_in = '0;
        step();
        chk("t2_sp_e1", 32'(ack_o), 1);
        step();
        chk("t2_sp_e2", 32'(ack_o), 1);
        step();
        chk("t2_sp_e3", 32'(ack_o), 0);

        // 3: correct Fibonacci sequence including the mod-256 wrap
        do_reset();
        foreach (fib_seq[i]) send_word(W'(fib_seq[i]), 1'b0);
        chk("t3_err", 32'(err_o), 0);
        chk("t3_cnt", 32'(word_cnt_o), 15);
        chk("t3_data", 32'(data_o), 121);

        // 4: broken sequence, error after the 4th word and sticky
        do_reset();
        foreach (bad_seq[i]) send_word(W'(bad_seq[i]), 1'b0);
        chk("t4_err", 32'(err_o), 1);
        chk("t4_cnt", 32'(word_cnt_o), 6);

        // 5: partial codeword and partial spacer stall the handshake
        do_reset();
        r_in = cw(8'h00);
        r_in[7] = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ack_o !== 1'b0 || valid_o !== 1'b0) seen = 1'b1;
        end
        chk("t5_partial_stall", 32'(seen), 0);
        r_in[7] = 2'b01;
        step();
        step();
        chk("t5_ack_e2", 32'(ack_o), 0);
        step();
        chk("t5_ack_e3", 32'(ack_o), 1);
        chk("t5_valid", 32'(valid_o), 1);
        r_in = '0;
        r_in[2] = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ack_o !== 1'b1) seen = 1'b1;
        end
        chk("t5_partial_spacer", 32'(seen), 0);
        r_in = '0;
        repeat (3) step();
        chk("t5_ack_fall", 32'(ack_o), 0);

        // 6: illegal code sets proto_err, stalls; reset mid-handshake clears
        do_reset();
        r_in = cw(8'h5A);
        r_in[3] = 2'b11;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ack_o !== 1'b0 || valid_o !== 1'b0) seen = 1'b1;
        end
        chk("t6_stall", 32'(seen), 0);
        chk("t6_proto", 32'(proto_err_o), 1);
        r_in = cw(8'h5A);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (ack_o === 1'b1) seen = 1'b1;
        end
        chk("t6_ack_after_clear", 32'(seen), 1);
        chk("t6_proto_sticky", 32'(proto_err_o), 1);
        rst = 1'b0;
        step();
        chk("t6_rst_ack", 32'(ack_o), 0);
        chk("t6_rst_proto", 32'(proto_err_o), 0);
        chk("t6_rst_cnt", 32'(word_cnt_o), 0);
        chk("t6_rst_data", 32'(data_o), 0);
        rst = 1'b1;

        // Random streams: mostly valid Fibonacci continuations with
        // occasional corrupt words, staggered bit arrival, counter saturation.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int k = 0; k < 24; k++) begin
                n = m_words.size();
                if (n < 2 || $urandom_range(0, 7) == 0)
                    w = W'($urandom);
                else
                    w = W'((m_words[n-1] + m_words[n-2]) % 256);
                send_word(w, 1'b1);
            end
            chk("rnd_cnt_sat", 32'(word_cnt_o), 32'(model_cnt()));
            chk("rnd_err", 32'(err_o), 32'(m_err));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
